// File: rtl/flptadder_pkg.sv
// Shared constants for the floating-point adder normalize/pack stage:
// default field widths, exponent bias/limits and the FSM state encoding.
package flptadder_pkg;

  localparam int EXP_W   = 5;
  localparam int FRAC_W  = 4;
  localparam int BIAS    = 15;
  localparam int EXP_MAX = (1 << EXP_W) - 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_NORM = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/flptadder_asm_fixed_point_adder.sv
// Unsigned W-bit adder with carry-in; z holds the sum plus the carry-out bit.
module flptadder_asm_fixed_point_adder #(
  parameter int W = 5
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W:0]   z
);

  assign z = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};

endmodule

// File: rtl/flptadder_normalize_pack.sv
// Normalizes the raw mantissa sum one bit per cycle and packs {sign, exp, frac},
// saturating on exponent overflow and flushing to +0 on underflow.
module flptadder_normalize_pack #(
  parameter int EXP_W  = flptadder_pkg::EXP_W,
  parameter int FRAC_W = flptadder_pkg::FRAC_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_sign,
  input  logic [FRAC_W+1:0]         in_mantissa,
  input  logic [EXP_W-1:0]          in_exponent,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [EXP_W+FRAC_W:0]     out_result,
  output logic                      out_overflow,
  output logic                      out_underflow,
  output logic                      out_zero
);

  import flptadder_pkg::*;

  localparam int M_W = FRAC_W + 2;
  localparam logic [EXP_W-1:0] L_EXP_MAX = {EXP_W{1'b1}};
  localparam logic [EXP_W-1:0] L_EXP_SAT = {{(EXP_W-1){1'b1}}, 1'b0};
  localparam logic [EXP_W-1:0] L_EXP_ONE = {{(EXP_W-1){1'b0}}, 1'b1};

  logic [1:0]               r_state;
  logic                     r_sign;
  logic [M_W-1:0]           r_mant;
  logic [EXP_W-1:0]         r_exp;
  logic [EXP_W+FRAC_W:0]    r_result;
  logic                     r_overflow;
  logic                     r_underflow;
  logic                     r_zero;

  logic                     w_isZero;
  logic                     w_carry;
  logic                     w_hidden;
  logic                     w_dec;
  logic [EXP_W-1:0]         w_adderB;
  logic                     w_adderCin;
  logic [EXP_W:0]           w_sum;
  logic                     w_incOverflow;

  assign w_isZero   = (r_mant == '0);
  assign w_carry    = r_mant[M_W-1];
  assign w_hidden   = r_mant[FRAC_W];
  assign w_dec      = ~w_carry & ~w_hidden;

  // One shared adder: +1 (b=0, cin=1) for carry, -1 (b=all-ones, cin=0) for left shift.
  assign w_adderB   = w_dec ? {EXP_W{1'b1}} : {EXP_W{1'b0}};
  assign w_adderCin = ~w_dec;

  flptadder_asm_fixed_point_adder #(
    .W(EXP_W)
  ) u_expAdder (
    .a  (r_exp),
    .b  (w_adderB),
    .cin(w_adderCin),
    .z  (w_sum)
  );

  assign w_incOverflow = (w_sum >= {1'b0, L_EXP_MAX});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_sign      <= 1'b0;
      r_mant      <= '0;
      r_exp       <= '0;
      r_result    <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
      r_zero      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_sign      <= in_sign;
            r_mant      <= in_mantissa;
            r_exp       <= in_exponent;
            r_result    <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
            r_zero      <= 1'b0;
            r_state     <= ST_NORM;
          end
        end

        ST_NORM: begin
          if (w_isZero) begin
            r_result <= '0;
            r_zero   <= 1'b1;
            r_state  <= ST_DONE;
          end else if (r_exp == L_EXP_MAX) begin
            r_result   <= {r_sign, L_EXP_SAT, {FRAC_W{1'b1}}};
            r_overflow <= 1'b1;
            r_state    <= ST_DONE;
          end else if (w_carry) begin
            // Right shift truncates: the new fraction is the old mantissa bits above bit 0.
            if (w_incOverflow) begin
              r_result   <= {r_sign, L_EXP_SAT, {FRAC_W{1'b1}}};
              r_overflow <= 1'b1;
            end else begin
              r_result <= {r_sign, w_sum[EXP_W-1:0], r_mant[FRAC_W:1]};
            end
            r_state <= ST_DONE;
          end else if (w_hidden) begin
            r_result <= {r_sign, r_exp, r_mant[FRAC_W-1:0]};
            r_state  <= ST_DONE;
          end else if (r_exp <= L_EXP_ONE) begin
            r_result    <= '0;
            r_underflow <= 1'b1;
            r_zero      <= 1'b1;
            r_state     <= ST_DONE;
          end else begin
            r_mant <= {r_mant[M_W-2:0], 1'b0};
            r_exp  <= w_sum[EXP_W-1:0];
          end
        end

        ST_DONE: begin
          if (out_ready) begin
            r_result    <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
            r_zero      <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready      = (r_state == ST_IDLE);
  assign out_valid     = (r_state == ST_DONE);
  assign out_result    = r_result;
  assign out_overflow  = r_overflow;
  assign out_underflow = r_underflow;
  assign out_zero      = r_zero;

endmodule

// File: tb/tb_flptadder_normalize_pack.sv
// Self-checking bench for flptadder_normalize_pack: directed cases, random
// operands against an arithmetic reference model, backpressure and reset.
module tb_flptadder_normalize_pack;

  localparam int EXP_W  = 5;
  localparam int FRAC_W = 4;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [5:0]  in_mantissa;
  logic [4:0]  in_exponent;
  logic        out_valid;
  logic        out_ready;
  logic [9:0]  out_result;
  logic        out_overflow;
  logic        out_underflow;
  logic        out_zero;

  int checks   = 0;
  int failures = 0;

  flptadder_normalize_pack #(
    .EXP_W (EXP_W),
    .FRAC_W(FRAC_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_sign      (in_sign),
    .in_mantissa  (in_mantissa),
    .in_exponent  (in_exponent),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_overflow (out_overflow),
    .out_underflow(out_underflow),
    .out_zero     (out_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: value-level normalization with plain integers.
  task automatic model(input bit s, input int m, input int e,
                       output logic [9:0] res, output logic [2:0] flags, output int lat);
    int k;
    bit ov, un, zr;
    k = 0; ov = 0; un = 0; zr = 0; res = '0;
    if (m == 0) begin
      zr = 1;
    end else if (e == 31) begin
      ov = 1;
    end else if (m >= 32) begin
      e = e + 1;
      m = m / 2;
      if (e >= 31) ov = 1;
    end else begin
      while (m < 16 && !un) begin
        if (e <= 1) begin
          un = 1;
          zr = 1;
        end else begin
          m = m * 2;
          e = e - 1;
          k = k + 1;
        end
      end
    end
    if (ov)
      res = 10'(int'(s) * 512 + 30 * 16 + 15);
    else if (!zr)
      res = 10'(int'(s) * 512 + e * 16 + (m - 16));
    flags = {ov, un, zr};
    lat = 2 + k;
  endtask

  // Drives one operand and waits for out_valid; leaves the result in DONE.
  // lat counts rising edges from the accept edge (inclusive) to out_valid.
  task automatic do_op(input bit s, input int m, input int e,
                       output int lat, output logic [9:0] res, output logic [2:0] flags,
                       output bit busyOk, output bit timedOut);
    int waitCyc;
    int edges;
    waitCyc = 0; busyOk = 1; timedOut = 1; lat = 0; res = '0; flags = '0;
    while (in_ready !== 1'b1 && waitCyc < 50) begin
      @(posedge clk); #1;
      waitCyc++;
    end
    if (in_ready === 1'b1) begin
      in_valid    = 1'b1;
      in_sign     = s;
      in_mantissa = 6'(m);
      in_exponent = 5'(e);
      @(posedge clk); #1;
      in_valid = 1'b0;
      edges = 1;
      if (out_valid === 1'b1) begin
        timedOut = 0;
        lat = edges;
      end else if (in_ready !== 1'b0) begin
        busyOk = 0;
      end
      while (timedOut && edges < 20) begin
        @(posedge clk); #1;
        edges++;
        if (out_valid === 1'b1) begin
          timedOut = 0;
          lat = edges;
        end else if (in_ready !== 1'b0) begin
          busyOk = 0;
        end
      end
      res   = out_result;
      flags = {out_overflow, out_underflow, out_zero};
      if (in_ready !== 1'b0) busyOk = 0;
    end
  endtask

  task automatic finish_op();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_handshake: in_ready=%b out_valid=%b, want 1/0", in_ready, out_valid);
    end
    checks++;
    if (out_result !== 10'h000 || {out_overflow, out_underflow, out_zero} !== 3'b000) begin
      failures++;
      $display("[TB] FAIL reset_outputs: result=%h flags=%b, want 000/000",
               out_result, {out_overflow, out_underflow, out_zero});
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL post_reset_idle: in_ready=%b out_valid=%b, want 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_directed();
    bit             dS[7]   = '{0, 1, 0, 0, 0, 0, 1};
    int             dM[7]   = '{16, 38, 3, 1, 0, 32, 20};
    int             dE[7]   = '{15, 15, 10, 3, 20, 30, 31};
    logic [9:0]     dRes[7] = '{10'h0F0, 10'h303, 10'h078, 10'h000, 10'h000, 10'h1EF, 10'h3EF};
    logic [2:0]     dFl[7]  = '{3'b000, 3'b000, 3'b000, 3'b011, 3'b001, 3'b100, 3'b100};
    int             dLat[7] = '{2, 2, 5, 4, 2, 2, 2};
    int lat;
    logic [9:0] res;
    logic [2:0] flags;
    bit busyOk, timedOut;
    for (int i = 0; i < 7; i++) begin
      do_op(dS[i], dM[i], dE[i], lat, res, flags, busyOk, timedOut);
      checks++;
      if (timedOut) begin
        failures++;
        $display("[TB] FAIL directed_%0d_timeout: no out_valid within bound", i);
      end else begin
        if (res !== dRes[i] || flags !== dFl[i]) begin
          failures++;
          $display("[TB] FAIL directed_%0d_result: got %h/%b, want %h/%b", i, res, flags, dRes[i], dFl[i]);
        end
        checks++;
        if (lat != dLat[i]) begin
          failures++;
          $display("[TB] FAIL directed_%0d_latency: got %0d, want %0d", i, lat, dLat[i]);
        end
        checks++;
        if (!busyOk) begin
          failures++;
          $display("[TB] FAIL directed_%0d_busy: in_ready=1 while busy, want 0", i);
        end
      end
      finish_op();
    end
  endtask

  task automatic test_random();
    int lat, eLat, m, e;
    bit s, busyOk, timedOut;
    logic [9:0] res, eRes;
    logic [2:0] flags, eFlags;
    for (int i = 0; i < 40; i++) begin
      s = 1'($urandom_range(0, 1));
      m = int'($urandom_range(0, 63));
      e = int'($urandom_range(1, 31));
      model(s, m, e, eRes, eFlags, eLat);
      do_op(s, m, e, lat, res, flags, busyOk, timedOut);
      checks++;
      if (timedOut) begin
        failures++;
        $display("[TB] FAIL random_%0d_timeout: m=%0d e=%0d no out_valid", i, m, e);
      end else begin
        if (res !== eRes || flags !== eFlags) begin
          failures++;
          $display("[TB] FAIL random_%0d_result: s=%0d m=%0d e=%0d got %h/%b, want %h/%b",
                   i, s, m, e, res, flags, eRes, eFlags);
        end
        checks++;
        if (lat != eLat || !busyOk) begin
          failures++;
          $display("[TB] FAIL random_%0d_timing: latency=%0d busyOk=%0d, want %0d/1", i, lat, busyOk, eLat);
        end
      end
      finish_op();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    logic [9:0] res;
    logic [2:0] flags;
    bit busyOk, timedOut;
    do_op(1'b1, 38, 15, lat, res, flags, busyOk, timedOut);
    checks++;
    if (timedOut || res !== 10'h303) begin
      failures++;
      $display("[TB] FAIL bp_result: got %h timeout=%0d, want 303", res, timedOut);
    end
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || out_result !== res || in_ready !== 1'b0 ||
          {out_overflow, out_underflow, out_zero} !== flags) begin
        failures++;
        $display("[TB] FAIL bp_hold_%0d: valid=%b result=%h in_ready=%b, want 1/%h/0",
                 c, out_valid, out_result, in_ready, res);
      end
    end
    finish_op();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL bp_release: in_ready=%b out_valid=%b, want 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_reset_mid_norm();
    int lat, eLat;
    logic [9:0] res, eRes;
    logic [2:0] flags, eFlags;
    bit busyOk, timedOut, sawValid;
    in_valid    = 1'b1;
    in_sign     = 1'b0;
    in_mantissa = 6'd1;
    in_exponent = 5'd20;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_result !== 10'h000) begin
      failures++;
      $display("[TB] FAIL midnorm_reset: valid=%b in_ready=%b result=%h, want 0/1/000",
               out_valid, in_ready, out_result);
    end
    @(negedge clk);
    rst = 1'b0;
    sawValid = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) sawValid = 1;
    end
    checks++;
    if (sawValid) begin
      failures++;
      $display("[TB] FAIL midnorm_stale: out_valid=1 after reset, want 0");
    end
    model(1'b0, 3, 10, eRes, eFlags, eLat);
    do_op(1'b0, 3, 10, lat, res, flags, busyOk, timedOut);
    checks++;
    if (timedOut || res !== eRes || flags !== eFlags || lat != eLat) begin
      failures++;
      $display("[TB] FAIL midnorm_recover: got %h/%b lat=%0d, want %h/%b lat=%0d",
               res, flags, lat, eRes, eFlags, eLat);
    end
    finish_op();
  endtask

  task automatic test_back_to_back();
    int lat, eLat, m, e;
    bit s, busyOk, timedOut;
    logic [9:0] res, eRes;
    logic [2:0] flags, eFlags;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      s = 1'($urandom_range(0, 1));
      m = int'($urandom_range(0, 63));
      e = int'($urandom_range(1, 31));
      model(s, m, e, eRes, eFlags, eLat);
      do_op(s, m, e, lat, res, flags, busyOk, timedOut);
      checks++;
      if (timedOut || res !== eRes || flags !== eFlags || lat != eLat) begin
        failures++;
        $display("[TB] FAIL b2b_%0d: m=%0d e=%0d got %h/%b lat=%0d, want %h/%b lat=%0d",
                 i, m, e, res, flags, lat, eRes, eFlags, eLat);
      end
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    rst         = 1'b1;
    in_valid    = 1'b0;
    in_sign     = 1'b0;
    in_mantissa = '0;
    in_exponent = '0;
    out_ready   = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_mid_norm();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
